mul_sequencer: RTL
==================

Name: mul_sequencer

Overview:
- Iterative shift-add multiplier and sequencer for the EX stage. It serves the MUL R-type instruction (funct 6'b01_1100, ALUControl 3'b101).
- While the product is being computed, it holds the pipeline with a stall request. It then presents the low WIDTH bits of the product for one Done cycle, and the EX result mux selects it in that cycle.
- It sits beside the ALU. The hazard logic ORs Stall into the IF/ID/EX enables.

Parameters:
- WIDTH, 32: operand and result width.
- STEP, 1: multiplier bits consumed per RUN cycle. Legal values are 1, 2 and 4. WIDTH must be divisible by STEP.
- EARLY_EXIT, 1: when 1, RUN ends as soon as the remaining multiplier bits are all zero.

Ports:
- CLK, input, 1: clock. All state changes on the rising edge.
- RST, input, 1: synchronous, active-high reset.
- Start, input, 1: EX holds a valid MUL. Sampled only in IDLE.
- Flush, input, 1: EX stage is being squashed (branch/jump). Aborts any operation in progress.
- SrcA, input, WIDTH: multiplicand. Captured on Start.
- SrcB, input, WIDTH: multiplier. Captured on Start.
- Stall, output, 1: freeze IF/ID/EX. Combinational: (IDLE and Start and not Flush) or RUN.
- Busy, output, 1: state is RUN (registered state decode).
- Done, output, 1: single-cycle pulse in state DONE.
- Result, output, WIDTH: low WIDTH bits of SrcA*SrcB. Held until the next accepted Start.

Behaviour:
- Clocking: one clock CLK. RST is synchronous and active-high, and it has priority over everything.
- On reset:
  - State goes to IDLE.
  - Result, accumulator, the shifted multiplicand register A, the shifted multiplier register B and the counter all go to 0.
  - Done is 0 and Busy is 0. Stall is 0 unless Start is high the same cycle RST falls; Stall follows the IDLE equation from the next cycle on.
- States:
  - IDLE to RUN: Start=1 and Flush=0. Load A=SrcA, B=SrcB, acc=0, cnt=WIDTH/STEP.
  - RUN:
    - Each cycle: acc += A * B[STEP-1:0], truncated to WIDTH bits. Then A <<= STEP, B >>= STEP (zero fill), cnt -= 1.
    - Go to DONE when cnt==1, or when EARLY_EXIT=1 and the post-shift B is 0.
    - On that same edge, Result takes the final acc value.
  - DONE: Done=1 and Stall=0, so the pipeline advances and consumes Result. Unconditionally go to IDLE next cycle. Start is ignored in DONE, because it is the same instruction leaving EX.
- RUN always lasts at least one cycle, including when SrcB=0.
- Latency (Start accepted at cycle T):
  - Without early exit, DONE is at T+WIDTH/STEP+1.
  - Stall is high for cycles T through DONE-1.
- Signedness: the low-WIDTH product is identical for signed and unsigned operands. No sign handling is needed and no high word is produced.
- Overflow: bits above WIDTH are silently discarded.
- Flush:
  - In IDLE, Flush suppresses Start: no load and Stall=0.
  - In RUN, Flush returns to IDLE next cycle. No Done is produced and Result is unchanged. Stall stays high during the cycle Flush is asserted.
  - In DONE, Flush has no effect (DONE goes to IDLE anyway). Done still pulses.
- Back-to-back MULs: IDLE re-accepts Start on the cycle after DONE. There is no bubble beyond the DONE cycle.
- SrcA and SrcB may change freely after the capture cycle.
- Reset mid-RUN: IDLE on the next edge, Result=0, no Done.

Test Plan:
1. Basic multiply, EARLY_EXIT=0, STEP=1. RST for 2 cycles, then Start at T with SrcA=3, SrcB=5. Required: Stall high at T..T+32, Busy high at T+1..T+32, Done pulse at T+33, Result=15 from T+33.
2. Early exit, EARLY_EXIT=1, STEP=1. SrcA=7, SrcB=5. Required: RUN at T+1..T+3, Done at T+4, Result=35. Then SrcA=7, SrcB=0: Done at T+2, Result=0.
3. Signed and overflow:
   - SrcA=32'hFFFF_FFFF (-1), SrcB=32'd6: Result=32'hFFFF_FFFA.
   - SrcA=32'h8000_0000, SrcB=2: Result=0.
   - SrcA=32'h1234_5678, SrcB=32'h0000_0100: Result=32'h3456_7800.
4. Flush mid-operation. Start with 9*9, then Flush at T+3. Required: IDLE at T+4, Stall low from T+4, no Done, Result still holds the previous value. Start 2*3 at T+4 gives Result=6.
5. Back-to-back and Start during DONE. First MUL 4*4; hold Start high through DONE. Required: Done at DONE, Result=16, the DONE cycle is not re-accepted. Second MUL 5*6 accepted the cycle after DONE gives Result=30.
6. Reset and STEP=4. With STEP=4 and EARLY_EXIT=0, 32'h0001_0001*3 takes 8 RUN cycles, then Done and Result=32'h0003_0003. Asserting RST mid-RUN gives IDLE, Result=0, Stall=0 with Start=0, and no Done.

Source files
------------

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for the EX stage: stalls the pipeline while
// running, then presents the low WIDTH product bits for one Done cycle.
//
// state  | meaning
// S_IDLE | waiting for an unflushed Start; Stall mirrors Start
// S_RUN  | consuming STEP multiplier bits per cycle, Stall held high
// S_DONE | Result valid, one-cycle Done pulse, pipeline advances
module mul_sequencer #(
  parameter int WIDTH      = 32,
  parameter int STEP       = 1,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int NSTEP = WIDTH / STEP;
  localparam int CNT_W = $clog2(NSTEP + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0] b_shift;
  logic             last_step;

  // A * B[STEP-1:0] as a small shift-add; STEP is at most 4
  always_comb begin
    partial = '0;
    for (int i = 0; i < STEP; i++) begin
      if (b_q[i]) partial = partial + (a_q << i);
    end
  end

  assign acc_sum   = acc_q + partial;
  assign b_shift   = b_q >> STEP;
  assign last_step = (cnt_q == CNT_W'(1)) || ((EARLY_EXIT != 0) && (b_shift == '0));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    stall_o  = 1'b0;
    done_o   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          stall_o = 1'b1;
          state_d = S_RUN;
          a_d     = src_a_i;
          b_d     = src_b_i;
          acc_d   = '0;
          cnt_d   = CNT_W'(NSTEP);
        end
      end
      S_RUN: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_sum;
          a_d   = a_q << STEP;
          b_d   = b_shift;
          cnt_d = cnt_q - CNT_W'(1);
          if (last_step) begin
            state_d  = S_DONE;
            result_d = acc_sum;
          end
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q == S_RUN);
  assign result_o = result_q;

endmodule
